// File: rtl/aes_sbox_lut_sync_pkg.sv
// Shared AES helpers: the forward S-box table used by SubWord/SubBytes logic.
package aes_pkg;

    typedef logic [7:0] byte_t;

    // Forward S-box as a full 256-way case so synthesis can map it to LUTs/ROM.
    function automatic byte_t aes_sbox(input byte_t b);
        byte_t s;
        // NOTE: assigning a default before the case keeps every path driven, so no latch can be inferred.
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aes_sbox_lut_sync_if.sv
// Byte lookup bus: the requester drives addr, the S-box returns dout one cycle later.
interface aes_sbox_lut_sync_if;
    import aes_pkg::*;

    byte_t addr;
    byte_t dout;

    modport master (output addr, input dout);
    modport slave  (input addr, output dout);
endinterface

// File: rtl/aes_sbox_lut_sync.sv
// Registered AES forward S-box: dout is SBOX[addr] sampled one clock earlier.
module aes_sbox_lut_sync
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    aes_sbox_lut_sync_if.slave  bus
);

    byte_t dout_d;
    byte_t dout_q;

    // Table lookup for the byte presented this cycle.
    always_comb begin
        dout_d = aes_sbox(bus.addr);
    end

    // Output register; reset clears it immediately and drops any in-flight value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 8'h00;
        end else begin
            // NOTE: non-blocking assignment so every flop samples its inputs from before the edge.
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;

endmodule

// File: tb/tb_aes_sbox_lut_sync.sv
// Directed bench for the registered AES S-box, with an independent GF(2^8) reference.
module tb_aes_sbox_lut_sync;

    logic clk;
    logic rst_n;

    aes_sbox_lut_sync_if bus ();
    aes_sbox_lut_sync_if w0 ();
    aes_sbox_lut_sync_if w1 ();
    aes_sbox_lut_sync_if w2 ();
    aes_sbox_lut_sync_if w3 ();

    aes_sbox_lut_sync dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    aes_sbox_lut_sync u_sw0 (.clk(clk), .rst_n(rst_n), .bus(w0));
    aes_sbox_lut_sync u_sw1 (.clk(clk), .rst_n(rst_n), .bus(w1));
    aes_sbox_lut_sync u_sw2 (.clk(clk), .rst_n(rst_n), .bus(w2));
    aes_sbox_lut_sync u_sw3 (.clk(clk), .rst_n(rst_n), .bus(w3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } vec_t;

    vec_t       spot [8];
    logic [7:0] ref_tab [256];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Multiplicative inverse followed by the FIPS-197 affine transform.
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            for (int i = 1; i < 256; i++) begin
                if (gf_mul(x, 8'(i)) == 8'h01) inv = 8'(i);
            end
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    initial begin
        logic [7:0] seq_a [4];
        logic [7:0] seq_e [4];
        logic [7:0] prev;
        bit         seen [256];
        int         dups;

        spot[0] = '{8'h00, 8'h63}; spot[1] = '{8'h01, 8'h7c};
        spot[2] = '{8'h09, 8'h01}; spot[3] = '{8'h10, 8'hca};
        spot[4] = '{8'h53, 8'hed}; spot[5] = '{8'h80, 8'hcd};
        spot[6] = '{8'hcf, 8'h8a}; spot[7] = '{8'hff, 8'h16};
        seq_a = '{8'h00, 8'h01, 8'hff, 8'h53};
        seq_e = '{8'h63, 8'h7c, 8'h16, 8'hed};
        for (int i = 0; i < 256; i++) ref_tab[i] = ref_sbox(8'(i));

        // Reset held with a live address: output must stay clear across edges.
        rst_n   = 1'b0;
        bus.addr = 8'h53;
        w0.addr = 8'h00; w1.addr = 8'h00; w2.addr = 8'h00; w3.addr = 8'h00;
        #2;
        check("reset_initial", {24'h0, bus.dout}, 32'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", {24'h0, bus.dout}, 32'h00);
        end

        // First edge after release loads the table value.
        rst_n = 1'b1;
        step();
        check("release_53", {24'h0, bus.dout}, 32'hed);

        // Spot values, one cycle after applying each address.
        for (int i = 0; i < 8; i++) begin
            bus.addr = spot[i].addr;
            step();
            check($sformatf("spot_%h", spot[i].addr), {24'h0, bus.dout}, {24'h0, spot[i].exp});
        end

        // Constant address keeps a constant output.
        bus.addr = 8'h10;
        step();
        check("hold_1", {24'h0, bus.dout}, 32'hca);
        step();
        check("hold_2", {24'h0, bus.dout}, 32'hca);

        // Back-to-back addresses; output must not follow addr before the edge.
        prev = 8'hca;
        for (int i = 0; i < 4; i++) begin
            bus.addr = seq_a[i];
            #1;
            check($sformatf("no_comb_%0d", i), {24'h0, bus.dout}, {24'h0, prev});
            @(posedge clk);
            #1;
            check($sformatf("pipe_%0d", i), {24'h0, bus.dout}, {24'h0, seq_e[i]});
            prev = seq_e[i];
        end

        // Asynchronous reset between edges clears the output at once.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {24'h0, bus.dout}, 32'h00);
        step();
        check("async_reset_edge", {24'h0, bus.dout}, 32'h00);
        rst_n = 1'b1;
        bus.addr = 8'h00;
        step();
        check("after_async", {24'h0, bus.dout}, 32'h63);

        // Exhaustive sweep against the arithmetic reference plus permutation check.
        dups = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int a = 0; a < 256; a++) begin
            bus.addr = 8'(a);
            step();
            check($sformatf("sweep_%h", 8'(a)), {24'h0, bus.dout}, {24'h0, ref_tab[a]});
            if (seen[bus.dout]) dups++;
            seen[bus.dout] = 1'b1;
        end
        check("permutation_dups", 32'(dups), 32'd0);

        // Mid-stream reset for one cycle, then release with C9.
        bus.addr = 8'h11; step();
        bus.addr = 8'h22; step();
        bus.addr = 8'h33; step();
        check("stream_33", {24'h0, bus.dout}, 32'hc3);
        rst_n = 1'b0;
        bus.addr = 8'h44;
        #1;
        check("mid_reset_now", {24'h0, bus.dout}, 32'h00);
        step();
        check("mid_reset_edge", {24'h0, bus.dout}, 32'h00);
        rst_n = 1'b1;
        bus.addr = 8'hc9;
        step();
        check("mid_release_c9", {24'h0, bus.dout}, 32'hdd);

        // SubWord of RotWord(09CF4F3C) = CF4F3C09.
        w3.addr = 8'hcf; w2.addr = 8'h4f; w1.addr = 8'h3c; w0.addr = 8'h09;
        step();
        check("subword", {w3.dout, w2.dout, w1.dout, w0.dout}, 32'h8a84eb01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
